// File: rtl/miner_work_scheduler_if.sv
// Purpose: bundles the work, core-control, result and status signals of miner_work_scheduler.
// Ports: slave  = scheduler view (takes work, drives the core, sources results and status).
//        master = environment view (host work source, hashing core, result consumer).
interface miner_work_scheduler_if;
  // host work offer
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic [31:0]  work_nonce_start;
  logic [31:0]  work_nonce_end;
  logic [7:0]   work_id;
  // hashing core control / status
  logic [255:0] core_midstate;
  logic [95:0]  core_data;
  logic         core_nonce_load;
  logic [31:0]  core_nonce_init;
  logic         core_run;
  logic [31:0]  core_nonce;
  logic         core_golden_valid;
  logic [31:0]  core_golden_nonce;
  // result queue head
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [7:0]   res_id;
  logic         res_done;
  // status
  logic         busy;
  logic         overflow;

  modport slave (
    input  work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end, work_id,
    output work_ready,
    output core_midstate, core_data, core_nonce_load, core_nonce_init, core_run,
    input  core_nonce, core_golden_valid, core_golden_nonce,
    output res_valid, res_nonce, res_id, res_done,
    input  res_ready,
    output busy, overflow
  );

  modport master (
    output work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end, work_id,
    input  work_ready,
    input  core_midstate, core_data, core_nonce_load, core_nonce_init, core_run,
    output core_nonce, core_golden_valid, core_golden_nonce,
    input  res_valid, res_nonce, res_id, res_done,
    output res_ready,
    input  busy, overflow
  );
endinterface

// File: rtl/miner_work_scheduler.sv
// Purpose: sequences a hashing core through work units, tags golden nonces with job IDs, queues results.
// Latency: accept -> LOAD next cycle -> RUN; done record pushed 1+PIPE_DEPTH cycles after the last nonce.
// Backpressure: work_ready low in LOAD/DRAIN; full result queue drops goldens (sticky overflow), stalls done.
// Ports: clk_i     system clock
//        reset_i   synchronous reset, active low (0 = reset)
//        bus       miner_work_scheduler_if.slave: work handshake, core control, result queue head, status
module miner_work_scheduler #(
  parameter int PIPE_DEPTH = 136,
  parameter int RES_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  miner_work_scheduler_if.slave  bus
);

  localparam int CW = $clog2(PIPE_DEPTH + 1);
  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [CW-1:0] PIPE_CNT = CW'(PIPE_DEPTH);
  localparam logic [AW:0]   RES_FULL = (AW+1)'(RES_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_e;

  typedef struct packed {
    logic [31:0] nonce;
    logic [7:0]  id;
    logic        done;
  } res_t;

  state_e        state_q, state_d;
  logic [255:0]  mid_q, mid_d;
  logic [95:0]   data_q, data_d;
  logic [31:0]   start_q, start_d;
  logic [31:0]   end_q, end_d;
  logic [7:0]    cur_id_q, cur_id_d;
  logic [7:0]    prev_id_q, prev_id_d;
  logic [CW-1:0] since_q, since_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          ovf_q, ovf_d;

  res_t          mem_q [RES_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic          work_rdy;
  logic          load;
  logic          run;
  logic          done_push;
  logic          full;
  logic          pop;
  logic          push_gold;
  logic          push;
  logic [7:0]    gold_id;
  res_t          push_rec;
  res_t          head;

  assign full = (cnt_q == RES_FULL);
  assign pop  = (cnt_q != '0) && bus.res_ready;

  // Nonces still in flight from the previous job emerge during the first PIPE_DEPTH
  // cycles after a load; in DRAIN only the current job can be in the pipe.
  assign gold_id   = ((state_q == S_DRAIN) || (since_q >= PIPE_CNT)) ? cur_id_q : prev_id_q;
  // A full queue still takes a golden when the head is leaving in the same cycle.
  assign push_gold = bus.core_golden_valid && (!full || pop);

  // FSM next state and control
  always_comb begin
    state_d   = state_q;
    mid_d     = mid_q;
    data_d    = data_q;
    start_d   = start_q;
    end_d     = end_q;
    cur_id_d  = cur_id_q;
    prev_id_d = prev_id_q;
    since_d   = since_q;
    drain_d   = drain_q;
    work_rdy  = 1'b0;
    load      = 1'b0;
    run       = 1'b0;
    done_push = 1'b0;

    case (state_q)
      S_IDLE: begin
        work_rdy = 1'b1;
        if (bus.work_valid) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        since_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        run      = 1'b1;
        work_rdy = 1'b1;
        if (since_q != PIPE_CNT) begin
          since_d = since_q + 1'b1;
        end
        // New work preempts the running job (no done record) and wins over range end.
        if (bus.work_valid) begin
          prev_id_d = cur_id_q;
          state_d   = S_LOAD;
        end else if (bus.core_nonce == end_q) begin
          drain_d = PIPE_CNT;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - 1'b1;
        end else if (!full && !bus.core_golden_valid) begin
          // Done waits for a free slot as seen at the start of the cycle and
          // yields the write port to a same-cycle golden.
          done_push = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (work_rdy && bus.work_valid) begin
      mid_d    = bus.work_midstate;
      data_d   = bus.work_data;
      start_d  = bus.work_nonce_start;
      end_d    = bus.work_nonce_end;
      cur_id_d = bus.work_id;
      since_d  = '0;
    end
  end

  // Result queue bookkeeping
  always_comb begin
    push     = push_gold || done_push;
    push_rec = push_gold ? '{nonce: bus.core_golden_nonce, id: gold_id, done: 1'b0}
                         : '{nonce: 32'd0, id: cur_id_q, done: 1'b1};
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    ovf_d = ovf_q | (bus.core_golden_valid && full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      mid_q     <= '0;
      data_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      cur_id_q  <= '0;
      prev_id_q <= '0;
      since_q   <= '0;
      drain_q   <= '0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mid_q     <= mid_d;
      data_q    <= data_d;
      start_q   <= start_d;
      end_q     <= end_d;
      cur_id_q  <= cur_id_d;
      prev_id_q <= prev_id_d;
      since_q   <= since_d;
      drain_q   <= drain_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q] <= push_rec;
    end
  end

  assign head = (cnt_q != '0) ? mem_q[rd_q] : '0;

  assign bus.work_ready      = work_rdy;
  assign bus.core_midstate   = mid_q;
  assign bus.core_data       = data_q;
  assign bus.core_nonce_load = load;
  assign bus.core_nonce_init = start_q;
  assign bus.core_run        = run;
  assign bus.res_valid       = (cnt_q != '0);
  assign bus.res_nonce       = head.nonce;
  assign bus.res_id          = head.id;
  assign bus.res_done        = head.done;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.overflow        = ovf_q;

endmodule

// File: tb/tb_miner_work_scheduler.sv
// Purpose: directed self-checking bench for miner_work_scheduler with a behavioural nonce counter as core.
// Latency: n/a (bench).
// Backpressure: bench drives res_ready explicitly per step.
module tb_miner_work_scheduler;

  localparam int PD = 136;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] model_nonce = 32'd0;

  int checks = 0;
  int errors = 0;

  // per-window observations
  int run_cnt, idle_at, val_at, wr_cnt;
  logic [31:0] nonces[$];
  // per-window stimulus
  int g_n[$];
  logic [31:0] g_v[$];
  int pop_n = -1;
  int acc_n = -1;

  localparam logic [255:0] MID1 =
    256'h228ea473_1a2b3c4d_5e6f7081_92a3b4c5_d6e7f809_1b2c3d4e_5f607182_af41f790;
  localparam logic [95:0] DATA1 = 96'h2194261a9395e64dbed17115;

  miner_work_scheduler_if ifc ();

  miner_work_scheduler #(.PIPE_DEPTH(PD), .RES_DEPTH(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  // behavioural core: nonce counter only
  always @(posedge clk) begin
    if (ifc.core_nonce_load) model_nonce <= ifc.core_nonce_init;
    else if (ifc.core_run)   model_nonce <= model_nonce + 32'd1;
  end
  assign ifc.core_nonce = model_nonce;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer work in IDLE, check the LOAD cycle, return in the first RUN cycle.
  task automatic start_job(input string tag, input logic [255:0] mid, input logic [95:0] dat,
                           input logic [31:0] s, input logic [31:0] e, input logic [7:0] id);
    ifc.work_midstate    = mid;
    ifc.work_data        = dat;
    ifc.work_nonce_start = s;
    ifc.work_nonce_end   = e;
    ifc.work_id          = id;
    ifc.work_valid       = 1'b1;
    chk({tag, "_ready"}, ifc.work_ready, 1'b1);
    tick();
    ifc.work_valid = 1'b0;
    chk({tag, "_load"},  ifc.core_nonce_load, 1'b1);
    chk({tag, "_init"},  ifc.core_nonce_init, s);
    chk({tag, "_mid"},   ifc.core_midstate, mid);
    chk({tag, "_ldrdy"}, ifc.work_ready, 1'b0);
    tick();
  endtask

  task automatic run_window(input int ncyc);
    run_cnt = 0; idle_at = -1; val_at = -1; wr_cnt = 0;
    nonces.delete();
    for (int n = 0; n < ncyc; n++) begin
      ifc.core_golden_valid = 1'b0;
      ifc.core_golden_nonce = 32'd0;
      foreach (g_n[i]) begin
        if (g_n[i] == n) begin
          ifc.core_golden_valid = 1'b1;
          ifc.core_golden_nonce = g_v[i];
        end
      end
      ifc.res_ready  = (n == pop_n);
      ifc.work_valid = (n == acc_n);
      if (ifc.core_run) begin run_cnt++; nonces.push_back(model_nonce); end
      if (ifc.work_ready) wr_cnt++;
      if (!ifc.busy && idle_at < 0) idle_at = n;
      if (ifc.res_valid && val_at < 0) val_at = n;
      tick();
    end
    ifc.core_golden_valid = 1'b0;
    ifc.res_ready = 1'b0;
    ifc.work_valid = 1'b0;
    g_n.delete(); g_v.delete();
    pop_n = -1; acc_n = -1;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] nonce, input logic [7:0] id,
                         input logic done);
    chk({tag, "_vld"},   ifc.res_valid, 1'b1);
    chk({tag, "_nonce"}, ifc.res_nonce, nonce);
    chk({tag, "_id"},    ifc.res_id, id);
    chk({tag, "_done"},  ifc.res_done, done);
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;
  endtask

  initial begin
    ifc.work_valid = 1'b0; ifc.work_midstate = '0; ifc.work_data = '0;
    ifc.work_nonce_start = '0; ifc.work_nonce_end = '0; ifc.work_id = '0;
    ifc.core_golden_valid = 1'b0; ifc.core_golden_nonce = '0; ifc.res_ready = 1'b0;

    // reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_wrdy", ifc.work_ready, 1'b1);
    chk("rst_run",  ifc.core_run, 1'b0);
    chk("rst_load", ifc.core_nonce_load, 1'b0);
    chk("rst_rvld", ifc.res_valid, 1'b0);
    chk("rst_ovf",  ifc.overflow, 1'b0);
    chk("rst_init", ifc.core_nonce_init, 32'd0);
    chk("rst_mid",  ifc.core_midstate, 256'd0);
    chk("rst_data", ifc.core_data, 96'd0);
    reset = 1'b1;
    tick();

    // T1: range 0e33327a..0e33338a, one golden 0e33337a reported during DRAIN
    start_job("t1", MID1, DATA1, 32'h0e33327a, 32'h0e33338a, 8'h05);
    chk("t1_data", ifc.core_data, DATA1);
    g_n.push_back(392); g_v.push_back(32'h0e33337a);
    run_window(420);
    chk("t1_runcnt", run_cnt, 273);
    chk("t1_first",  nonces[0], 32'h0e33327a);
    chk("t1_last",   nonces[272], 32'h0e33338a);
    chk("t1_valat",  val_at, 393);
    chk("t1_idleat", idle_at, 410);
    chk("t1_wrcnt",  wr_cnt, 283);
    pop_chk("t1_gold", 32'h0e33337a, 8'h05, 1'b0);
    pop_chk("t1_done", 32'd0, 8'h05, 1'b1);
    chk("t1_empty", ifc.res_valid, 1'b0);
    chk("t1_ovf",   ifc.overflow, 1'b0);

    // T2: wrapping range FFFFFFFE..00000001
    start_job("t2", 256'h1, 96'h2, 32'hFFFFFFFE, 32'h00000001, 8'h0A);
    run_window(150);
    chk("t2_runcnt", run_cnt, 4);
    chk("t2_n0", nonces[0], 32'hFFFFFFFE);
    chk("t2_n1", nonces[1], 32'hFFFFFFFF);
    chk("t2_n2", nonces[2], 32'h00000000);
    chk("t2_n3", nonces[3], 32'h00000001);
    chk("t2_valat",  val_at, 141);
    chk("t2_idleat", idle_at, 141);
    pop_chk("t2_done", 32'd0, 8'h0A, 1'b1);
    chk("t2_empty", ifc.res_valid, 1'b0);

    // T3: preempt id 01 with id 02 at n=146; tag boundary at since_load 135/136
    start_job("t3", 256'h3, 96'h3, 32'h00000000, 32'h0000FFFF, 8'h01);
    ifc.work_midstate = 256'h4; ifc.work_data = 96'h4;
    ifc.work_nonce_start = 32'h00010000; ifc.work_nonce_end = 32'h000100FF; ifc.work_id = 8'h02;
    acc_n = 146;
    g_n.push_back(186); g_v.push_back(32'h0000AAAA);
    g_n.push_back(283); g_v.push_back(32'h0000BBBB);
    g_n.push_back(284); g_v.push_back(32'h0000CCCC);
    run_window(545);
    chk("t3_runcnt", run_cnt, 403);
    chk("t3_oldnon", nonces[146], 32'h00000092);
    chk("t3_newnon", nonces[147], 32'h00010000);
    chk("t3_wrcnt",  wr_cnt, 407);
    chk("t3_valat",  val_at, 187);
    chk("t3_idleat", idle_at, 541);
    pop_chk("t3_g40",  32'h0000AAAA, 8'h01, 1'b0);
    pop_chk("t3_g135", 32'h0000BBBB, 8'h01, 1'b0);
    pop_chk("t3_g136", 32'h0000CCCC, 8'h02, 1'b0);
    pop_chk("t3_done", 32'd0, 8'h02, 1'b1);
    chk("t3_empty", ifc.res_valid, 1'b0);

    // T4: five goldens with res_ready=0 -> four queued, overflow set
    for (int i = 0; i < 5; i++) begin
      g_n.push_back(i); g_v.push_back(32'h11 * (i + 1));
    end
    run_window(8);
    chk("t4_ovf", ifc.overflow, 1'b1);
    chk("t4_valat", val_at, 1);
    pop_chk("t4_p0", 32'h11, 8'h02, 1'b0);
    pop_chk("t4_p1", 32'h22, 8'h02, 1'b0);
    pop_chk("t4_p2", 32'h33, 8'h02, 1'b0);
    pop_chk("t4_p3", 32'h44, 8'h02, 1'b0);
    chk("t4_empty", ifc.res_valid, 1'b0);
    chk("t4_sticky", ifc.overflow, 1'b1);

    // fill to full, then push and pop on a full queue in the same cycle
    for (int i = 0; i < 5; i++) begin
      g_n.push_back(i); g_v.push_back(32'hA1 + i);
    end
    pop_n = 4;
    run_window(6);

    // T5: DRAIN finishes against a full queue; done goes in the cycle after the pop
    start_job("t5", 256'h5, 96'h5, 32'h00000100, 32'h00000103, 8'h07);
    pop_n = 150;
    run_window(156);
    chk("t5_runcnt", run_cnt, 4);
    chk("t5_valat",  val_at, 0);
    chk("t5_idleat", idle_at, 152);
    chk("t5_wrcnt",  wr_cnt, 8);
    pop_chk("t5_p0", 32'hA3, 8'h02, 1'b0);
    pop_chk("t5_p1", 32'hA4, 8'h02, 1'b0);
    pop_chk("t5_p2", 32'hA5, 8'h02, 1'b0);
    pop_chk("t5_done", 32'd0, 8'h07, 1'b1);
    chk("t5_empty", ifc.res_valid, 1'b0);

    // T6: reset for one cycle in the middle of RUN
    start_job("t6", 256'h6, 96'h6, 32'h00000000, 32'h0000FFFF, 8'h09);
    g_n.push_back(5); g_v.push_back(32'h00000005);
    run_window(20);
    chk("t6_pre_run", ifc.core_run, 1'b1);
    chk("t6_pre_vld", ifc.res_valid, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_busy", ifc.busy, 1'b0);
    chk("t6_run",  ifc.core_run, 1'b0);
    chk("t6_rvld", ifc.res_valid, 1'b0);
    chk("t6_wrdy", ifc.work_ready, 1'b1);
    chk("t6_ovf",  ifc.overflow, 1'b0);
    chk("t6_init", ifc.core_nonce_init, 32'd0);
    run_window(200);
    chk("t6_norun",  run_cnt, 0);
    chk("t6_nodone", val_at, -1);

    // single-nonce range (start == end)
    start_job("t7", 256'h7, 96'h7, 32'h00001234, 32'h00001234, 8'h0B);
    run_window(145);
    chk("t7_runcnt", run_cnt, 1);
    chk("t7_nonce",  nonces[0], 32'h00001234);
    chk("t7_idleat", idle_at, 138);
    pop_chk("t7_done", 32'd0, 8'h0B, 1'b1);
    chk("t7_empty", ifc.res_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
